// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions five raw pushbuttons. Each channel is synchronized, debounced,
//   and then tracked by a small press FSM that turns level changes into
//   single-cycle event pulses.
//
// Parameters
//   DEBOUNCE_CYCLES   consecutive stable cycles needed to accept a level change
//   LONG_PRESS_CYCLES cycles a debounced press is held before long_pulse fires
//
// Ports
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-low reset
//   btn_raw[4:0]   raw buttons {down, right, middle, left, up}, async, bouncy
//   btn_level      debounced level per channel
//   press_pulse    one cycle on accepted press
//   release_pulse  one cycle on accepted release
//   long_pulse     one cycle when a press has been held LONG_PRESS_CYCLES
//   click_pulse    one cycle on release of a press that never went long
//
// Press FSM (one per channel)
//   state        | meaning
//   -------------+---------------------------------------------
//   ST_IDLE      | debounced level 0
//   ST_HELD      | debounced level 1, hold timer running
//   ST_LONG_HELD | debounced level 1, long_pulse already issued
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES   = 2000000,
   parameter int LONG_PRESS_CYCLES = 300000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] btn_raw,
   output logic [4:0] btn_level,
   output logic [4:0] press_pulse,
   output logic [4:0] release_pulse,
   output logic [4:0] long_pulse,
   output logic [4:0] click_pulse
);

   localparam int NCH = 5;
   localparam int DW  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HW  = $clog2(LONG_PRESS_CYCLES) + 1;

   // Debounce accepts on the edge where the count would reach DEBOUNCE_CYCLES.
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   // Long fires on the edge where the hold count reaches LONG_PRESS_CYCLES-1.
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HELD      = 2'd1,
      ST_LONG_HELD = 2'd2
   } state_t;

   logic [NCH-1:0] sync_a;
   logic [NCH-1:0] sync_b;

   logic [DW-1:0]  deb_cnt     [NCH];
   logic [DW-1:0]  deb_cnt_nxt [NCH];
   logic [NCH-1:0] accept;

   state_t         state       [NCH];
   state_t         state_nxt   [NCH];
   logic [HW-1:0]  hold_cnt    [NCH];
   logic [HW-1:0]  hold_nxt    [NCH];

   logic [NCH-1:0] press_nxt;
   logic [NCH-1:0] release_nxt;
   logic [NCH-1:0] long_nxt;
   logic [NCH-1:0] click_nxt;

   // Debounce: count cycles where the synchronized input disagrees with the
   // accepted level; any agreeing cycle restarts the count.
   always_comb begin
      accept = '0;
      for (int i = 0; i < NCH; i++) begin
         deb_cnt_nxt[i] = '0;
         if (sync_b[i] != btn_level[i]) begin
            if (deb_cnt[i] == DEB_LAST) begin
               accept[i] = 1'b1;
            end else begin
               deb_cnt_nxt[i] = deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Press FSM next-state and pulse decode. Pulses are registered, so they
   // line up with the cycle in which btn_level first shows the new value.
   always_comb begin
      press_nxt   = '0;
      release_nxt = '0;
      long_nxt    = '0;
      click_nxt   = '0;
      for (int i = 0; i < NCH; i++) begin
         state_nxt[i] = state[i];
         hold_nxt[i]  = hold_cnt[i];
         case (state[i])
            ST_IDLE: begin
               hold_nxt[i] = '0;
               if (accept[i]) begin
                  state_nxt[i] = ST_HELD;
                  press_nxt[i] = 1'b1;
               end
            end
            ST_HELD: begin
               if (accept[i]) begin
                  state_nxt[i]   = ST_IDLE;
                  hold_nxt[i]    = '0;
                  release_nxt[i] = 1'b1;
                  click_nxt[i]   = 1'b1;
               end else begin
                  hold_nxt[i] = hold_cnt[i] + HW'(1);
                  if (hold_cnt[i] == HOLD_LAST) begin
                     state_nxt[i] = ST_LONG_HELD;
                     long_nxt[i]  = 1'b1;
                  end
               end
            end
            ST_LONG_HELD: begin
               // Hold count frozen here so it can never wrap during a long press.
               if (accept[i]) begin
                  state_nxt[i]   = ST_IDLE;
                  hold_nxt[i]    = '0;
                  release_nxt[i] = 1'b1;
               end
            end
            default: begin
               state_nxt[i] = ST_IDLE;
               hold_nxt[i]  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a        <= '0;
         sync_b        <= '0;
         btn_level     <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         long_pulse    <= '0;
         click_pulse   <= '0;
         for (int i = 0; i < NCH; i++) begin
            deb_cnt[i]  <= '0;
            state[i]    <= ST_IDLE;
            hold_cnt[i] <= '0;
         end
      end else begin
         sync_a        <= btn_raw;
         sync_b        <= sync_a;
         btn_level     <= btn_level ^ accept;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
         click_pulse   <= click_nxt;
         for (int i = 0; i < NCH; i++) begin
            deb_cnt[i]  <= deb_cnt_nxt[i];
            state[i]    <= state_nxt[i];
            hold_cnt[i] <= hold_nxt[i];
         end
      end
   end

endmodule
